mcu_fpga_regbus: RTL and testbench

// - Parametrised MCU<->FPGA parallel register bus, successor to the single-shot 17x8 bus.
// - Synchronises all asynchronous MCU pins, runs a full 4-phase req/ack handshake and

---
 rtl/mcu_fpga_bus_pkg.sv | 12 +
 rtl/mcu_bus_sync.sv | 31 +++
 rtl/mcu_fpga_regbus.sv | 173 +++++++++++++++++
 tb/tb_mcu_fpga_regbus.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_fpga_bus_pkg.sv
// Shared types and defaults for the MCU<->FPGA parallel register bus.
package mcu_fpga_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } bus_state_t;

    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/mcu_bus_sync.sv
// Multi-flop synchroniser for a bundle of asynchronous MCU pins.
module mcu_bus_sync
    import mcu_fpga_bus_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/mcu_fpga_regbus.sv
// MCU<->FPGA register bus: synchronised 4-phase req/ack handshake, NUM_REGS
// write registers, NUM_REGS read sources, registered tristate read path.
module mcu_fpga_regbus
    import mcu_fpga_bus_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 5,
    parameter int                NUM_REGS    = 17,
    parameter int                SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int                TIMEOUT     = 1023,
    parameter logic [DATA_W-1:0] RST_VAL     = '0,
    parameter logic [DATA_W-1:0] ERR_VAL     = 8'hEE
) (
    input  logic                         CLK50,
    input  logic                         RST_N,
    input  logic                         mcu_mstr,
    input  logic                         write_enable,
    input  logic [ADDR_W-1:0]            address,
    inout  wire  [DATA_W-1:0]            data,
    output logic                         fpga_ack,
    input  logic [NUM_REGS*DATA_W-1:0]   input_pins_state,
    output logic [NUM_REGS*DATA_W-1:0]   output_pins_state,
    output logic [NUM_REGS-1:0]          wr_pulse,
    input  logic                         clr_err,
    output logic                         addr_err,
    output logic                         timeout_err
);

    localparam int SYNC_W = 2 + ADDR_W + DATA_W;
    localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [SYNC_W-1:0]          w_sync_d;
    logic [SYNC_W-1:0]          w_sync_q;
    logic                       w_req_s;
    logic                       w_we_s;
    logic [ADDR_W-1:0]          w_addr_s;
    logic [DATA_W-1:0]          w_data_s;
    logic                       w_req_rise;
    logic [NUM_REGS-1:0]        w_sel;
    logic                       w_addr_ok;
    logic [DATA_W-1:0]          w_rd_val;

    bus_state_t                 r_state;
    logic                       r_req_q;
    logic                       r_we;
    logic [ADDR_W-1:0]          r_addr;
    logic [DATA_W-1:0]          r_wdata;
    logic [DATA_W-1:0]          r_rd_q;
    logic                       r_data_oe;
    logic                       r_ack;
    logic [NUM_REGS*DATA_W-1:0] r_out;
    logic [NUM_REGS-1:0]        r_wr_pulse;
    logic                       r_addr_err;
    logic                       r_tmo_err;
    logic [CNT_W-1:0]           r_tmo_cnt;

    // Request and its qualifiers share one synchroniser so they age together.
    assign w_sync_d = {mcu_mstr, write_enable, address, data};

    mcu_bus_sync #(
        .WIDTH       (SYNC_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (CLK50),
        .i_rst_n (RST_N),
        .i_d     (w_sync_d),
        .o_q     (w_sync_q)
    );

    assign {w_req_s, w_we_s, w_addr_s, w_data_s} = w_sync_q;
    assign w_req_rise = w_req_s & ~r_req_q;

    always_comb begin
        w_sel     = '0;
        w_addr_ok = 1'b0;
        w_rd_val  = ERR_VAL;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_addr == ADDR_W'(i)) begin
                w_sel[i]  = 1'b1;
                w_addr_ok = 1'b1;
                w_rd_val  = input_pins_state[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_req_q    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data_oe  <= 1'b0;
            r_ack      <= 1'b0;
            r_out      <= {NUM_REGS{RST_VAL}};
            r_wr_pulse <= '0;
            r_addr_err <= 1'b0;
            r_tmo_err  <= 1'b0;
            r_tmo_cnt  <= '0;
        end else begin
            r_req_q    <= w_req_s;
            r_wr_pulse <= '0;
            // Clear first so an error raised below in the same cycle wins.
            if (clr_err) begin
                r_addr_err <= 1'b0;
                r_tmo_err  <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_ack     <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (w_req_rise) begin
                        r_we    <= w_we_s;
                        r_addr  <= w_addr_s;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!w_addr_ok) begin
                        r_addr_err <= 1'b1;
                    end else if (r_we) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (w_sel[i]) begin
                                r_out[i*DATA_W +: DATA_W] <= r_wdata;
                            end
                        end
                        r_wr_pulse <= w_sel;
                    end
                    r_ack     <= 1'b1;
                    r_data_oe <= ~r_we;
                    r_tmo_cnt <= '0;
                    r_state   <= ACK;
                end
                ACK: begin
                    if (!w_req_s) begin
                        r_ack     <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_state   <= IDLE;
                    end else if (TIMEOUT != 0) begin
                        if (r_tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                            r_tmo_err <= 1'b1;
                            r_ack     <= 1'b0;
                            r_data_oe <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Data-only registers: never observed before a qualifying control event.
    always_ff @(posedge CLK50) begin
        if (r_state == IDLE && w_req_rise) begin
            r_wdata <= w_data_s;
        end
        if (r_state == ACCESS) begin
            r_rd_q <= w_rd_val;
        end
    end

    assign data              = r_data_oe ? r_rd_q : 'z;
    assign fpga_ack          = r_ack;
    assign output_pins_state = r_out;
    assign wr_pulse          = r_wr_pulse;
    assign addr_err          = r_addr_err;
    assign timeout_err       = r_tmo_err;

endmodule

// File: tb/tb_mcu_fpga_regbus.sv
// Scoreboard bench for mcu_fpga_regbus: directed transactions push expectations,
// a monitor pops and compares on every fpga_ack rising edge.
module tb_mcu_fpga_regbus;

    localparam int DW  = 8;
    localparam int AW  = 5;
    localparam int NR  = 17;
    localparam int TMO = 8;

    typedef struct {
        logic              rd;
        logic [DW-1:0]     rdat;
        logic [NR-1:0]     wr;
        logic [NR*DW-1:0]  outv;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mcu_mstr = 1'b0;
    logic              write_enable = 1'b0;
    logic [AW-1:0]     address = '0;
    logic              clr_err = 1'b0;
    logic              tb_drv = 1'b0;
    logic [DW-1:0]     tb_d = '0;
    wire  [DW-1:0]     data;
    logic              fpga_ack;
    logic [NR*DW-1:0]  in_pins = '0;
    logic [NR*DW-1:0]  out_pins;
    logic [NR-1:0]     wr_pulse;
    logic              addr_err;
    logic              timeout_err;

    logic [DW-1:0]     m_in  [NR];
    logic [DW-1:0]     m_out [NR];
    exp_t              q[$];
    int                n_cmp = 0;
    int                n_bad = 0;

    assign data = tb_drv ? tb_d : 8'bz;

    always #5 clk = ~clk;

    mcu_fpga_regbus #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .NUM_REGS    (NR),
        .SYNC_STAGES (2),
        .TIMEOUT     (TMO),
        .RST_VAL     (8'h00),
        .ERR_VAL     (8'hEE)
    ) dut (
        .CLK50             (clk),
        .RST_N             (rst_n),
        .mcu_mstr          (mcu_mstr),
        .write_enable      (write_enable),
        .address           (address),
        .data              (data),
        .fpga_ack          (fpga_ack),
        .input_pins_state  (in_pins),
        .output_pins_state (out_pins),
        .wr_pulse          (wr_pulse),
        .clr_err           (clr_err),
        .addr_err          (addr_err),
        .timeout_err       (timeout_err)
    );

    task automatic chk(input string nm, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] pack_out();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_out[i];
        return v;
    endfunction

    task automatic push_exp(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        int   ai;
        ai = int'(a);
        e.rd = ~we;
        e.wr = '0;
        if (ai < NR) begin
            e.rdat = m_in[ai];
            if (we) begin
                m_out[ai] = d;
                e.wr = NR'(1) << ai;
            end
        end else begin
            e.rdat = 8'hEE;
        end
        e.outv = pack_out();
        q.push_back(e);
    endtask

    task automatic wait_ack(output int up);
        up = 0;
        while (up < 40 && !fpga_ack) begin
            @(posedge clk); #1;
            up++;
        end
        if (!fpga_ack) chk("ack_wait", 136'(fpga_ack), 136'(1));
    endtask

    task automatic xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int up, output int dn, output logic err_at_ack);
        push_exp(we, a, d);
        @(negedge clk);
        address = a; write_enable = we; tb_d = d; tb_drv = we; mcu_mstr = 1'b1;
        wait_ack(up);
        err_at_ack = addr_err;
        @(negedge clk);
        mcu_mstr = 1'b0; tb_drv = 1'b0; address = ~a;
        dn = 0;
        while (dn < 40 && fpga_ack) begin
            @(posedge clk); #1;
            dn++;
        end
        if (fpga_ack) chk("ack_release", 136'(fpga_ack), 136'(0));
        repeat (2) @(negedge clk);
    endtask

    // Monitor: one scoreboard entry per acknowledge.
    initial begin
        logic ack_prev;
        exp_t e;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && fpga_ack && !ack_prev) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
                end else begin
                    e = q.pop_front();
                    if (e.rd) chk("rd_data", 136'(data), 136'(e.rdat));
                    chk("wr_pulse", 136'(wr_pulse), 136'(e.wr));
                    chk("out_regs", out_pins, e.outv);
                end
            end
            ack_prev = fpga_ack;
        end
    end

    initial begin
        int   up, dn, n, extra;
        logic ea;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;

        for (int i = 0; i < NR; i++) begin
            m_in[i]  = 8'(i * 37 + 5);
            m_out[i] = 8'h00;
        end
        m_in[16] = 8'h3C;
        for (int i = 0; i < NR; i++) in_pins[i*DW +: DW] = m_in[i];

        repeat (3) @(negedge clk);
        chk("rst_ack", 136'(fpga_ack), 136'(0));
        chk("rst_oe", 136'(dut.r_data_oe), 136'(0));
        chk("rst_out", out_pins, '0);
        chk("rst_wr", 136'(wr_pulse), 136'(0));
        chk("rst_aerr", 136'(addr_err), 136'(0));
        chk("rst_terr", 136'(timeout_err), 136'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write, with latency measurement.
        xfer(1'b1, 5'd3, 8'hA5, up, dn, ea);
        chk("wr_lat_up", 136'(up), 136'(4));
        chk("wr_lat_dn", 136'(dn), 136'(3));

        // Read from the top register.
        xfer(1'b0, 5'd16, 8'h00, up, dn, ea);
        chk("rd_lat_up", 136'(up), 136'(4));
        chk("rd_oe_off", 136'(dut.r_data_oe), 136'(0));

        // Out-of-range write then read.
        xfer(1'b1, 5'd20, 8'h77, up, dn, ea);
        chk("bad_wr_aerr", 136'(addr_err), 136'(1));
        xfer(1'b0, 5'd20, 8'h00, up, dn, ea);
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
        chk("clr_aerr", 136'(addr_err), 136'(0));

        // Error set coincident with clr_err held high: set wins that cycle.
        clr_err = 1'b1;
        xfer(1'b0, 5'd25, 8'h00, up, dn, ea);
        chk("set_wins", 136'(ea), 136'(1));
        chk("clr_held", 136'(addr_err), 136'(0));
        clr_err = 1'b0;

        // Timeout: hold the request high.
        push_exp(1'b1, 5'd5, 8'h5A);
        @(negedge clk);
        address = 5'd5; write_enable = 1'b1; tb_d = 8'h5A; tb_drv = 1'b1; mcu_mstr = 1'b1;
        wait_ack(up);
        n = 1;
        while (n < 40) begin
            @(posedge clk); #1;
            if (!fpga_ack) break;
            n++;
        end
        chk("tmo_ack_len", 136'(n), 136'(TMO));
        chk("tmo_err", 136'(timeout_err), 136'(1));
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (fpga_ack) extra++;
        end
        chk("tmo_no_retrig", 136'(extra), 136'(0));
        @(negedge clk);
        mcu_mstr = 1'b0; tb_drv = 1'b0;
        repeat (4) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
        chk("clr_terr", 136'(timeout_err), 136'(0));

        // Back-to-back write/read pairs.
        for (int k = 0; k < 10; k++) begin
            ra = AW'($urandom_range(0, NR - 1));
            rd = DW'($urandom_range(0, 255));
            xfer(1'b1, ra, rd, up, dn, ea);
            ra = AW'($urandom_range(0, NR - 1));
            xfer(1'b0, ra, 8'h00, up, dn, ea);
        end

        // Asynchronous reset in the middle of a read acknowledge.
        push_exp(1'b0, 5'd16, 8'h00);
        @(negedge clk);
        address = 5'd16; write_enable = 1'b0; mcu_mstr = 1'b1;
        wait_ack(up);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ack", 136'(fpga_ack), 136'(0));
        chk("arst_oe", 136'(dut.r_data_oe), 136'(0));
        chk("arst_out", out_pins, '0);
        chk("arst_wr", 136'(wr_pulse), 136'(0));
        mcu_mstr = 1'b0;
        for (int i = 0; i < NR; i++) m_out[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        xfer(1'b1, 5'd7, 8'hC3, up, dn, ea);
        xfer(1'b0, 5'd7, 8'h00, up, dn, ea);

        repeat (5) @(negedge clk);
        chk("sb_empty", 136'(q.size()), 136'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
